// File: rtl/ysyx_pkg.sv
// ysyx_pkg
//   Shared definitions for the single-issue multi-cycle execution controller:
//   RV32I opcode constants, fixed instruction encodings and the controller
//   FSM state type.
//   No ports (package).

package ysyx_pkg;

  // Major opcodes (inst[6:0]) that the controller must tell apart
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Full-word encodings
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } exec_state_e;

endpackage

// File: rtl/ysyx_opc_class.sv
// ysyx_opc_class
//   Purely combinational opcode classifier used by the execution controller.
//   Ports:
//     opcode  in  7  inst[6:0] of the latched instruction
//     is_mem  out 1  load or store, needs a data-memory phase
//     wb_en   out 1  instruction writes the register file in WB

module ysyx_opc_class
  import ysyx_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       is_mem,
  output logic       wb_en
);

  // Only loads and stores visit MEM. Register write-back is granted to the
  // known opcodes that produce an rd value; store, branch, system and any
  // unrecognised opcode fall through to the default and never write.
  always_comb begin
    is_mem = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    wb_en  = 1'b0;
    case (opcode)
      OPC_LOAD,
      OPC_OP_IMM,
      OPC_OP,
      OPC_LUI,
      OPC_AUIPC,
      OPC_JAL,
      OPC_JALR:   wb_en = 1'b1;
      default:    wb_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_exec_ctrl.sv
// ysyx_exec_ctrl
//   Multi-cycle execution controller: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
//   Owns the PC, the latched instruction and the retired-instruction counter.
//   Optional feature macro: YSYX_EBREAK_HALT_EN -- when defined, an ebreak
//   retiring in WB keeps the PC and parks the core in HALT; otherwise ebreak
//   retires like a nop and halt is tied low.
//   Ports:
//     clk         in  1   clock, rising edge
//     rst         in  1   asynchronous active-high reset
//     ifu_req     out 1   instruction-fetch request
//     ifu_addr    out 32  fetch address (= pc)
//     ifu_rvalid  in  1   fetched data valid
//     ifu_rdata   in  32  fetched instruction
//     inst        out 32  latched instruction
//     pc_next     in  32  next PC from the datapath
//     pc          out 32  current PC
//     lsu_req     out 1   data-memory request
//     lsu_done    in  1   data-memory access complete
//     rf_wen      out 1   register-file write enable
//     halt        out 1   core stopped
//     inst_cnt    out 64  retired-instruction counter

module ysyx_exec_ctrl
  import ysyx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
)(
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  output logic [31:0] ifu_addr,
  input  logic        ifu_rvalid,
  input  logic [31:0] ifu_rdata,
  output logic [31:0] inst,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic        lsu_req,
  input  logic        lsu_done,
  output logic        rf_wen,
  output logic        halt,
  output logic [63:0] inst_cnt
);

  exec_state_e state;
  exec_state_e state_nxt;

  logic fetch_armed;
  logic is_mem;
  logic wb_en;
  logic inst_load;
  logic retire;
  logic ebreak_hit;

  ysyx_opc_class u_opc_class (
    .opcode (inst[6:0]),
    .is_mem (is_mem),
    .wb_en  (wb_en)
  );

`ifdef YSYX_EBREAK_HALT_EN
  assign ebreak_hit = (inst == INST_EBREAK);
  assign halt       = (state == HALT);
`else
  assign ebreak_hit = 1'b0;
  assign halt       = 1'b0;
`endif

  assign ifu_addr = pc;

  // State register. fetch_armed stays low from reset until the first clock
  // edge after release, so the first FETCH cycle issues no request and any
  // stale ifu_rvalid from an access aborted by reset cannot be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      fetch_armed <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_armed <= 1'b1;
    end
  end

  // Next-state and control outputs. Handshake inputs are only looked at in
  // the state that owns them, so ifu_rvalid outside FETCH and lsu_done
  // outside MEM have no effect. HALT drives nothing and never leaves.
  always_comb begin
    state_nxt = state;
    ifu_req   = 1'b0;
    lsu_req   = 1'b0;
    rf_wen    = 1'b0;
    inst_load = 1'b0;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        if (fetch_armed) begin
          ifu_req = 1'b1;
          if (ifu_rvalid) begin
            inst_load = 1'b1;
            state_nxt = DECODE;
          end
        end
      end
      DECODE: state_nxt = EXEC;
      EXEC:   state_nxt = is_mem ? MEM : WB;
      MEM: begin
        lsu_req = 1'b1;
        if (lsu_done) begin
          state_nxt = WB;
        end
      end
      WB: begin
        rf_wen    = wb_en;
        retire    = 1'b1;
        state_nxt = ebreak_hit ? HALT : FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // Architectural state. The instruction is captured on the accepting fetch
  // edge and then held until the next accept; PC and counter move only on
  // retirement. A halting ebreak still counts as retired but keeps its PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      inst     <= INST_NOP;
      inst_cnt <= 64'd0;
    end else begin
      if (inst_load) begin
        inst <= ifu_rdata;
      end
      if (retire) begin
        inst_cnt <= inst_cnt + 64'd1;
        if (!ebreak_hit) begin
          pc <= pc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_exec_ctrl.sv
// tb_ysyx_exec_ctrl
//   Directed self-checking bench for ysyx_exec_ctrl. Inputs change and outputs
//   are sampled on the falling clock edge; every expected value below is
//   worked out by hand from the instruction sequence.

module tb_ysyx_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic [31:0] inst;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic        lsu_req;
  logic        lsu_done;
  logic        rf_wen;
  logic        halt;
  logic [63:0] inst_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_pc;
  logic [63:0] exp_cnt;

  ysyx_exec_ctrl #(.RESET_PC(32'h8000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .ifu_req    (ifu_req),
    .ifu_addr   (ifu_addr),
    .ifu_rvalid (ifu_rvalid),
    .ifu_rdata  (ifu_rdata),
    .inst       (inst),
    .pc_next    (pc_next),
    .pc         (pc),
    .lsu_req    (lsu_req),
    .lsu_done   (lsu_done),
    .rf_wen     (rf_wen),
    .halt       (halt),
    .inst_cnt   (inst_cnt)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Drive all stimulus inputs in one place
  task automatic applyStimulus(input logic rvalid, input logic [31:0] rdata,
                               input logic done, input logic [31:0] pcn);
    ifu_rvalid = rvalid;
    ifu_rdata  = rdata;
    lsu_done   = done;
    pc_next    = pcn;
  endtask

  // One comparison: count it, and on mismatch count and report it
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Walk one instruction through the FSM, starting at a falling edge where
  // the controller is in FETCH with its request raised. Spurious handshake
  // pulses are injected in DECODE to show they are ignored.
  task automatic runInst(input string name, input logic [31:0] word,
                         input int fetch_wait, input logic exp_mem,
                         input int mem_wait, input logic [31:0] pcn,
                         input logic exp_wen, input logic [31:0] exp_pc_after,
                         input logic exp_halt_after);
    int lsu_cycles;
    checkOutput({name, ":ifu_req"}, 64'(ifu_req), 64'd1);
    checkOutput({name, ":ifu_addr"}, 64'(ifu_addr), 64'(exp_pc));
    for (int i = 0; i < fetch_wait; i++) begin
      applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0);
      @(negedge clk);
    end
    checkOutput({name, ":ifu_req_held"}, 64'(ifu_req), 64'd1);
    applyStimulus(1'b1, word, 1'b0, 32'h0);
    @(negedge clk);
    // DECODE
    checkOutput({name, ":inst_decode"}, 64'(inst), 64'(word));
    checkOutput({name, ":ifu_req_decode"}, 64'(ifu_req), 64'd0);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0);
    @(negedge clk);
    // EXEC
    checkOutput({name, ":inst_exec"}, 64'(inst), 64'(word));
    checkOutput({name, ":rf_wen_exec"}, 64'(rf_wen), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    lsu_cycles = 0;
    if (exp_mem) begin
      for (int i = 0; i < mem_wait; i++) begin
        if (lsu_req) lsu_cycles++;
        @(negedge clk);
      end
      if (lsu_req) lsu_cycles++;
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    end
    checkOutput({name, ":lsu_cycles"}, 64'(lsu_cycles),
                exp_mem ? 64'(mem_wait + 1) : 64'd0);
    // WB
    checkOutput({name, ":rf_wen_wb"}, 64'(rf_wen), 64'(exp_wen));
    checkOutput({name, ":lsu_req_wb"}, 64'(lsu_req), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, pcn);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    exp_cnt = exp_cnt + 64'd1;
    exp_pc  = exp_pc_after;
    checkOutput({name, ":pc"}, 64'(pc), 64'(exp_pc));
    checkOutput({name, ":inst_cnt"}, inst_cnt, exp_cnt);
    checkOutput({name, ":halt"}, 64'(halt), 64'(exp_halt_after));
    checkOutput({name, ":ifu_req_next"}, 64'(ifu_req), 64'(!exp_halt_after));
    checkOutput({name, ":rf_wen_after"}, 64'(rf_wen), 64'd0);
  endtask

  // Directed sequence
  initial begin
    int req_seen;
    int wen_seen;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    checkOutput("rst:pc", 64'(pc), 64'h8000_0000);
    checkOutput("rst:inst", 64'(inst), 64'h0000_0013);
    checkOutput("rst:inst_cnt", inst_cnt, 64'd0);
    checkOutput("rst:ifu_req", 64'(ifu_req), 64'd0);
    checkOutput("rst:lsu_req", 64'(lsu_req), 64'd0);
    checkOutput("rst:rf_wen", 64'(rf_wen), 64'd0);
    checkOutput("rst:halt", 64'(halt), 64'd0);

    rst = 1'b0;
    #1;
    checkOutput("rel:ifu_req_pre_edge", 64'(ifu_req), 64'd0);
    @(negedge clk);

    exp_pc  = 32'h8000_0000;
    exp_cnt = 64'd0;

    runInst("addi", 32'h0050_0093, 2, 1'b0, 0, 32'h8000_0004, 1'b1, 32'h8000_0004, 1'b0);
    runInst("lw",   32'h0001_2083, 0, 1'b1, 2, 32'h8000_0008, 1'b1, 32'h8000_0008, 1'b0);
    runInst("sw",   32'h0011_2023, 1, 1'b1, 2, 32'h8000_000C, 1'b0, 32'h8000_000C, 1'b0);
    runInst("beq",  32'h0000_0063, 0, 1'b0, 0, 32'h8000_0040, 1'b0, 32'h8000_0040, 1'b0);
    runInst("lui",  32'h1234_50B7, 0, 1'b0, 0, 32'h8000_0044, 1'b1, 32'h8000_0044, 1'b0);
    runInst("unk",  32'h0000_007F, 1, 1'b0, 0, 32'h8000_0048, 1'b0, 32'h8000_0048, 1'b0);
    runInst("lw1",  32'h0040_A183, 0, 1'b1, 0, 32'h8000_004C, 1'b1, 32'h8000_004C, 1'b0);

`ifdef YSYX_EBREAK_HALT_EN
    runInst("ebreak", 32'h0010_0073, 0, 1'b0, 0, 32'h8000_0050, 1'b0, 32'h8000_004C, 1'b1);
    req_seen = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 32'h0050_0093, 1'b1, 32'h9000_0000);
      @(negedge clk);
      if (ifu_req || lsu_req || rf_wen) req_seen++;
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("halt:req_cycles", 64'(req_seen), 64'd0);
    checkOutput("halt:pc_frozen", 64'(pc), 64'h8000_004C);
    checkOutput("halt:cnt_frozen", inst_cnt, 64'd8);
    checkOutput("halt:halt_held", 64'(halt), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("halt:cleared", 64'(halt), 64'd0);
    exp_pc  = 32'h8000_0000;
    exp_cnt = 64'd0;
`else
    runInst("ebreak", 32'h0010_0073, 0, 1'b0, 0, 32'h8000_0050, 1'b0, 32'h8000_0050, 1'b0);
`endif

    runInst("addi2", 32'h0010_0113, 0, 1'b0, 0, exp_pc + 32'h4, 1'b1, exp_pc + 32'h4, 1'b0);

    // Load into MEM, then reset in the middle of the data access
    applyStimulus(1'b1, 32'h0001_2083, 1'b0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("abort:lsu_req_before", 64'(lsu_req), 64'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort:pc", 64'(pc), 64'h8000_0000);
    checkOutput("abort:inst", 64'(inst), 64'h0000_0013);
    checkOutput("abort:inst_cnt", inst_cnt, 64'd0);
    checkOutput("abort:lsu_req", 64'(lsu_req), 64'd0);
    checkOutput("abort:ifu_req", 64'(ifu_req), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 32'h0010_0093, 1'b1, 32'h1234_5678);
    #1;
    checkOutput("abort:ifu_req_pre_edge", 64'(ifu_req), 64'd0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("abort:ifu_req_armed", 64'(ifu_req), 64'd1);
    checkOutput("abort:ifu_addr", 64'(ifu_addr), 64'h8000_0000);
    checkOutput("abort:inst_not_taken", 64'(inst), 64'h0000_0013);
    checkOutput("abort:cnt_zero", inst_cnt, 64'd0);
    wen_seen = 0;
    req_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rf_wen) wen_seen++;
      if (ifu_req) req_seen++;
    end
    checkOutput("abort:rf_wen_cycles", 64'(wen_seen), 64'd0);
    checkOutput("abort:still_fetching", 64'(req_seen), 64'd3);
    checkOutput("abort:pc_final", 64'(pc), 64'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_exec_ctrl.md
YSYX_EXEC_CTRL -- requirements
Module: ysyx_exec_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port ifu_req  out  1  instruction-fetch request to imem.
REQ-005 SHALL have port ifu_addr  out  32  fetch address, equal to pc.
REQ-006 SHALL have port ifu_rvalid  in  1  imem data valid.
REQ-007 SHALL have port ifu_rdata  in  32  fetched instruction.
REQ-008 SHALL have port inst  out  32  latched instruction driving decode and immediate extension.
REQ-009 SHALL have port pc_next  in  32  next PC computed by datapath.
REQ-010 SHALL have port pc  out  32  current PC register.
REQ-011 SHALL have port lsu_req  out  1  load/store request to dmem.
REQ-012 SHALL have port lsu_done  in  1  dmem access complete.
REQ-013 SHALL have port rf_wen  out  1  register-file write enable.
REQ-014 SHALL have port halt  out  1  core stopped.
REQ-015 SHALL have port inst_cnt  out  64  retired-instruction counter.

Function
REQ-016 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-017 FETCH: SHALL hold ifu_req=1 until ifu_rvalid=1, then latch ifu_rdata into inst and go to DECODE next cycle.
REQ-018 DECODE and EXEC SHALL each last exactly one cycle; inst stable throughout.
REQ-019 EXEC SHALL go to MEM if inst[6:0] is 7'b0000011 (load) or 7'b0100011 (store), else WB.
REQ-020 MEM: SHALL hold lsu_req=1 until lsu_done=1, then go to WB; lsu_done in first MEM cycle gives one-cycle MEM.
REQ-021 WB SHALL last one cycle, load pc<=pc_next, increment inst_cnt by 1 (wrap at 2^64), go to FETCH.
REQ-022 rf_wen SHALL be 1 only in WB and only when opcode is not store (0100011), branch (1100011) or system (1110011).
REQ-023 ifu_rvalid outside FETCH and lsu_done outside MEM SHALL be ignored.
REQ-024 Non-memory instruction latency SHALL be fetch wait + 4 cycles (FETCH accept, DECODE, EXEC, WB).
REQ-025 Unknown opcodes SHALL follow the non-memory path with rf_wen=0.
REQ-026 HALT SHALL be absorbing: halt=1, ifu_req=0, lsu_req=0, rf_wen=0, pc and inst_cnt frozen.

Reset
REQ-027 On rst=1, asynchronously: state=FETCH, pc=RESET_PC, inst=32'h0000_0013, inst_cnt=0, ifu_req=0 until first edge after release, lsu_req=0, rf_wen=0, halt=0.
REQ-028 Reset mid-transaction SHALL abort it; late ifu_rvalid/lsu_done from the aborted access before first FETCH request SHALL be ignored.

Configuration
REQ-029 With YSYX_EBREAK_HALT_EN defined, inst==32'h0010_0073 in WB SHALL retire (inst_cnt+1, pc unchanged) and enter HALT.
REQ-030 Without YSYX_EBREAK_HALT_EN, ebreak SHALL retire as a nop (pc<=pc_next) and halt SHALL be tied 0.

Structure
REQ-031 Package ysyx_pkg SHALL hold opcode constants (LOAD, STORE, BRANCH, SYSTEM), EBREAK encoding, and the FSM state enum.
REQ-032 Sub-module ysyx_opc_class SHALL classify inst[6:0] into is_mem and wb_en; all state stays in ysyx_exec_ctrl.

Verification
REQ-033 addi at 0x8000_0000, ifu_rvalid 2 cycles after req -> rf_wen pulse 5 cycles after first ifu_req, pc=pc_next, inst_cnt=1.
REQ-034 lw with lsu_done 3 cycles late -> lsu_req high 3 cycles, WB rf_wen=1; sw same -> rf_wen=0.
REQ-035 beq with pc_next=0x8000_0040 -> rf_wen=0, next ifu_addr=0x8000_0040.
REQ-036 ebreak with macro -> inst_cnt incremented, halt=1, no further ifu_req for 100 cycles; without macro -> fetch continues at pc_next.
REQ-037 rst asserted during MEM, lsu_done pulsed after release -> pc=0x8000_0000, state FETCH, inst_cnt=0, no rf_wen.
